// File: rtl/numrecog_pkg.sv
// Shared definitions for the number-recognition datapath: row geometry,
// score width and the matcher's FSM state encoding.
package numrecog_pkg;

  localparam int ROW_W    = 16;
  localparam int NUM_ROWS = 16;
  localparam int SCORE_W  = 9;
  localparam int PC_W     = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/digit_template_matcher_row_match_count.sv
// Count of agreeing pixels between one template row and one image row.
module row_match_count
  import numrecog_pkg::*;
(
  input  logic [ROW_W-1:0] tmpl_row,
  input  logic [ROW_W-1:0] img_row,
  output logic [PC_W-1:0]  pc
);

  logic [ROW_W-1:0] agree;

  assign agree = ~(tmpl_row ^ img_row);

  always_comb begin
    pc = '0;
    for (int i = 0; i < ROW_W; i++) pc = pc + PC_W'(agree[i]);
  end

endmodule

// File: rtl/digit_template_matcher.sv
// Scans all digit templates row by row against the image buffer and
// reports the digit with the highest bit-agreement score.
module digit_template_matcher
  import numrecog_pkg::*;
#(
  parameter int NUM_DIGITS = 10,
  parameter int MIN_SCORE  = 200
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [3:0]          tmpl_sel,
  output logic [3:0]          tmpl_addr,
  input  logic [ROW_W-1:0]    tmpl_row,
  output logic [3:0]          img_addr,
  input  logic [ROW_W-1:0]    img_row,
  output logic                busy,
  output logic                done,
  output logic [3:0]          result_digit,
  output logic [SCORE_W-1:0]  result_score,
  output logic                result_valid
);

  state_e               state;
  logic [3:0]           dig_cnt;
  logic [3:0]           row_cnt;
  logic [SCORE_W-1:0]   acc;
  logic [SCORE_W-1:0]   best;
  logic [3:0]           best_dig;
  logic [PC_W-1:0]      pc;
  logic [SCORE_W-1:0]   sum;
  logic                 last_row;
  logic                 last_dig;

  row_match_count u_match (
    .tmpl_row (tmpl_row),
    .img_row  (img_row),
    .pc       (pc)
  );

  assign sum      = acc + SCORE_W'(pc);
  assign last_row = (row_cnt == 4'(NUM_ROWS - 1));
  assign last_dig = (dig_cnt == 4'(NUM_DIGITS - 1));

  // Addresses come straight from the counters so the ROM sees them at the
  // start of the cycle and its row is consumed in the same cycle.
  assign tmpl_sel  = dig_cnt;
  assign tmpl_addr = row_cnt;
  assign img_addr  = row_cnt;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dig_cnt      <= '0;
      row_cnt      <= '0;
      acc          <= '0;
      best         <= '0;
      best_dig     <= '0;
      done         <= 1'b0;
      result_digit <= '0;
      result_score <= '0;
      result_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            dig_cnt  <= '0;
            row_cnt  <= '0;
            acc      <= '0;
            best     <= '0;
            best_dig <= '0;
          end
        end
        SCAN: begin
          if (!last_row) begin
            acc     <= sum;
            row_cnt <= row_cnt + 4'd1;
          end else begin
            // Strict compare: on a tie the earlier (lower) digit is kept.
            if (dig_cnt == 4'd0 || sum > best) begin
              best     <= sum;
              best_dig <= dig_cnt;
            end
            acc     <= '0;
            row_cnt <= '0;
            if (last_dig) state   <= DONE;
            else          dig_cnt <= dig_cnt + 4'd1;
          end
        end
        DONE: begin
          done         <= 1'b1;
          result_digit <= best_dig;
          result_score <= best;
          result_valid <= ({1'b0, best} >= 10'(MIN_SCORE));
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_template_matcher.sv
// Self-checking bench: randomized templates/images against a score model
// computed directly from pixel agreement counts.
module tb_digit_template_matcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;

  logic [15:0] tmpl [0:15][0:15];
  logic [15:0] img  [0:15];

  logic [3:0]  sel_a, addr_a, iaddr_a, rdig_a;
  logic [15:0] trow_a, irow_a;
  logic        busy_a, done_a, rval_a;
  logic [8:0]  rscore_a;

  logic [3:0]  sel_b, addr_b, iaddr_b, rdig_b;
  logic [15:0] trow_b, irow_b;
  logic        busy_b, done_b, rval_b;
  logic [8:0]  rscore_b;

  int checks = 0;
  int errors = 0;

  logic [3:0]  sel_log  [0:170];
  logic [3:0]  addr_log [0:170];
  logic [3:0]  iaddr_log[0:170];
  logic        busy_log [0:170];
  int          done_at;
  int          done_cnt;

  always #5 clk = ~clk;

  always_comb begin
    trow_a = tmpl[sel_a][addr_a];
    irow_a = img[iaddr_a];
    trow_b = tmpl[sel_b][addr_b];
    irow_b = img[iaddr_b];
  end

  digit_template_matcher dut_a (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tmpl_sel(sel_a), .tmpl_addr(addr_a), .tmpl_row(trow_a),
    .img_addr(iaddr_a), .img_row(irow_a),
    .busy(busy_a), .done(done_a),
    .result_digit(rdig_a), .result_score(rscore_a), .result_valid(rval_a)
  );

  digit_template_matcher #(.NUM_DIGITS(10), .MIN_SCORE(220)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tmpl_sel(sel_b), .tmpl_addr(addr_b), .tmpl_row(trow_b),
    .img_addr(iaddr_b), .img_row(irow_b),
    .busy(busy_b), .done(done_b),
    .result_digit(rdig_b), .result_score(rscore_b), .result_valid(rval_b)
  );

  // Reference: score(d) = number of equal pixels; winner = first maximum.
  function automatic void model(output logic [3:0] dig, output logic [8:0] score);
    int best_s = -1;
    dig = 4'd0;
    for (int d = 0; d < 10; d++) begin
      int s = 0;
      for (int r = 0; r < 16; r++) s += 16 - $countones(tmpl[d][r] ^ img[r]);
      if (s > best_s) begin
        best_s = s;
        dig = 4'(d);
      end
    end
    score = 9'(best_s);
  endfunction

  // Caller is at a negedge; start is presented for edge E0, log index n is
  // sampled 1ns after edge E0+n.
  task automatic run_scan(input bit repulse);
    done_at  = -1;
    done_cnt = 0;
    start = 1'b1;
    for (int n = 0; n <= 170; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      sel_log[n]   = sel_a;
      addr_log[n]  = addr_a;
      iaddr_log[n] = iaddr_a;
      busy_log[n]  = busy_a;
      if (done_a) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (repulse && (n == 5 || n == 100)) start = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic rand_templates();
    for (int d = 0; d < 16; d++)
      for (int r = 0; r < 16; r++) tmpl[d][r] = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errors++;
      $display("FAIL reset_ctrl busy=%b done=%b expected 0 0", busy_a, done_a); end
    checks++; if (sel_a !== 4'd0 || addr_a !== 4'd0 || iaddr_a !== 4'd0) begin errors++;
      $display("FAIL reset_addr sel=%0d addr=%0d img=%0d expected 0", sel_a, addr_a, iaddr_a); end
    checks++; if (rdig_a !== 4'd0 || rscore_a !== 9'd0 || rval_a !== 1'b0) begin errors++;
      $display("FAIL reset_result dig=%0d score=%0d valid=%b expected 0", rdig_a, rscore_a, rval_a); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_match3();
    logic [3:0] ed; logic [8:0] es;
    rand_templates();
    for (int r = 0; r < 16; r++) img[r] = tmpl[3][r];
    model(ed, es);
    run_scan(1'b0);
    checks++; if (done_at != 161 || done_cnt != 1) begin errors++;
      $display("FAIL match3_done_timing at=%0d count=%0d expected 161 1", done_at, done_cnt); end
    checks++; if (busy_log[0] !== 1'b1 || busy_log[160] !== 1'b1 || busy_log[161] !== 1'b0) begin errors++;
      $display("FAIL match3_busy b0=%b b160=%b b161=%b expected 1 1 0", busy_log[0], busy_log[160], busy_log[161]); end
    checks++; if (rdig_a !== 4'd3 || rscore_a !== 9'd256 || rval_a !== 1'b1) begin errors++;
      $display("FAIL match3_result dig=%0d score=%0d valid=%b expected 3 256 1", rdig_a, rscore_a, rval_a); end
    checks++; if (rdig_a !== ed || rscore_a !== es) begin errors++;
      $display("FAIL match3_model dig=%0d score=%0d expected %0d %0d", rdig_a, rscore_a, ed, es); end
  endtask

  task automatic test_all_zero();
    for (int d = 0; d < 16; d++)
      for (int r = 0; r < 16; r++) tmpl[d][r] = 16'hFFFF;
    for (int r = 0; r < 16; r++) img[r] = 16'h0000;
    run_scan(1'b0);
    checks++; if (rdig_a !== 4'd0 || rscore_a !== 9'd0 || rval_a !== 1'b0) begin errors++;
      $display("FAIL zero_result dig=%0d score=%0d valid=%b expected 0 0 0", rdig_a, rscore_a, rval_a); end
  endtask

  task automatic test_tie();
    rand_templates();
    for (int r = 0; r < 16; r++) begin
      img[r] = 16'($urandom);
      tmpl[2][r] = img[r];
      tmpl[5][r] = img[r];
    end
    run_scan(1'b0);
    checks++; if (rdig_a !== 4'd2 || rscore_a !== 9'd256 || rval_a !== 1'b1) begin errors++;
      $display("FAIL tie_result dig=%0d score=%0d valid=%b expected 2 256 1", rdig_a, rscore_a, rval_a); end
  endtask

  task automatic test_dist40();
    logic [3:0] ed; logic [8:0] es;
    bit flip [256];
    int cnt, diff;
    for (int r = 0; r < 16; r++) img[r] = 16'($urandom);
    foreach (flip[i]) flip[i] = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      int p = $urandom_range(0, 255);
      if (!flip[p]) begin flip[p] = 1'b1; cnt++; end
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) tmpl[7][r][c] = img[r][c] ^ flip[r*16+c];
    for (int d = 0; d < 10; d++) begin
      if (d == 7) continue;
      do begin
        diff = 0;
        for (int r = 0; r < 16; r++) begin
          tmpl[d][r] = 16'($urandom);
          diff += $countones(tmpl[d][r] ^ img[r]);
        end
      end while (diff < 100);
    end
    model(ed, es);
    run_scan(1'b0);
    checks++; if (rdig_a !== 4'd7 || rscore_a !== 9'd216 || rval_a !== 1'b1) begin errors++;
      $display("FAIL dist40_result dig=%0d score=%0d valid=%b expected 7 216 1", rdig_a, rscore_a, rval_a); end
    checks++; if (rdig_a !== ed || rscore_a !== es) begin errors++;
      $display("FAIL dist40_model dig=%0d score=%0d expected %0d %0d", rdig_a, rscore_a, ed, es); end
    checks++; if (rdig_b !== 4'd7 || rscore_b !== 9'd216 || rval_b !== 1'b0) begin errors++;
      $display("FAIL dist40_min220 dig=%0d score=%0d valid=%b expected 7 216 0", rdig_b, rscore_b, rval_b); end
  endtask

  task automatic test_ignore_start();
    logic [3:0] ed; logic [8:0] es;
    int bad_seq;
    rand_templates();
    for (int r = 0; r < 16; r++) img[r] = tmpl[6][r] ^ 16'($urandom & $urandom & $urandom);
    model(ed, es);
    run_scan(1'b1);
    bad_seq = 0;
    for (int n = 0; n < 160; n++)
      if (sel_log[n] !== 4'(n / 16) || addr_log[n] !== 4'(n % 16) || iaddr_log[n] !== 4'(n % 16))
        bad_seq++;
    checks++; if (bad_seq != 0) begin errors++;
      $display("FAIL ignore_addr_seq bad_cycles=%0d expected 0", bad_seq); end
    checks++; if (done_at != 161 || done_cnt != 1) begin errors++;
      $display("FAIL ignore_done at=%0d count=%0d expected 161 1", done_at, done_cnt); end
    checks++; if (busy_log[165] !== 1'b0) begin errors++;
      $display("FAIL ignore_not_queued busy=%b expected 0", busy_log[165]); end
    checks++; if (rdig_a !== ed || rscore_a !== es) begin errors++;
      $display("FAIL ignore_result dig=%0d score=%0d expected %0d %0d", rdig_a, rscore_a, ed, es); end
  endtask

  task automatic test_reset_midscan();
    logic [3:0] ed; logic [8:0] es;
    rand_templates();
    for (int r = 0; r < 16; r++) img[r] = tmpl[4][r] ^ 16'($urandom & $urandom & $urandom);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0 || done_a !== 1'b0 || sel_a !== 4'd0 || addr_a !== 4'd0 || iaddr_a !== 4'd0) begin errors++;
      $display("FAIL midscan_ctrl busy=%b done=%b sel=%0d addr=%0d img=%0d expected 0", busy_a, done_a, sel_a, addr_a, iaddr_a); end
    checks++; if (rdig_a !== 4'd0 || rscore_a !== 9'd0 || rval_a !== 1'b0) begin errors++;
      $display("FAIL midscan_result dig=%0d score=%0d valid=%b expected 0", rdig_a, rscore_a, rval_a); end
    @(negedge clk);
    model(ed, es);
    rst_n = 1'b1;
    run_scan(1'b0);
    checks++; if (done_at != 161 || rdig_a !== ed || rscore_a !== es || rval_a !== (es >= 9'd200)) begin errors++;
      $display("FAIL midscan_restart at=%0d dig=%0d score=%0d valid=%b expected 161 %0d %0d %b",
               done_at, rdig_a, rscore_a, rval_a, ed, es, (es >= 9'd200)); end
  endtask

  task automatic test_random();
    logic [3:0] ed; logic [8:0] es;
    for (int it = 0; it < 6; it++) begin
      for (int r = 0; r < 16; r++) img[r] = 16'($urandom);
      for (int d = 0; d < 16; d++)
        for (int r = 0; r < 16; r++)
          tmpl[d][r] = (it % 2 == 0) ? img[r] ^ 16'($urandom & $urandom)
                                     : img[r] ^ 16'($urandom & $urandom & $urandom);
      model(ed, es);
      run_scan(1'b0);
      checks++; if (rdig_a !== ed || rscore_a !== es || rval_a !== (es >= 9'd200)) begin errors++;
        $display("FAIL random_a it=%0d dig=%0d score=%0d valid=%b expected %0d %0d %b",
                 it, rdig_a, rscore_a, rval_a, ed, es, (es >= 9'd200)); end
      checks++; if (rdig_b !== ed || rscore_b !== es || rval_b !== (es >= 9'd220)) begin errors++;
        $display("FAIL random_b it=%0d dig=%0d score=%0d valid=%b expected %0d %0d %b",
                 it, rdig_b, rscore_b, rval_b, ed, es, (es >= 9'd220)); end
    end
  endtask

  initial begin
    for (int d = 0; d < 16; d++)
      for (int r = 0; r < 16; r++) tmpl[d][r] = 16'h0;
    for (int r = 0; r < 16; r++) img[r] = 16'h0;
    test_reset();
    test_match3();
    test_all_zero();
    test_tie();
    test_dist40();
    test_ignore_start();
    test_reset_midscan();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
